alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, datapath width; legal values 32 or 64.
REQ-002 The block SHALL have parameter STAGES, default 1, result latency in cycles; legal range 1..4.
REQ-003 The block SHALL have parameter TRANS_ID_BITS, default 3, width of the tag carried with each operation.
REQ-004 The block SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port flush_i, input, 1, kill all in-flight operations.
REQ-007 The block SHALL have port in_valid_i, input, 1, an operation is offered.
REQ-008 The block SHALL have port in_ready_o, output, 1, the operation is accepted this cycle.
REQ-009 The block SHALL have port op_i, input, 5, operator code.
REQ-010 The block SHALL have ports operand_a_i and operand_b_i, input, XLEN each, source operands.
REQ-011 The block SHALL have port trans_id_i, input, TRANS_ID_BITS, tag.
REQ-012 The block SHALL have port out_valid_o, output, 1, a result is presented.
REQ-013 The block SHALL have port out_ready_i, input, 1, the consumer takes the result.
REQ-014 The block SHALL have ports result_o (XLEN), branch_res_o (1) and trans_id_o (TRANS_ID_BITS), outputs, result, branch decision and returned tag.

Function
REQ-015 Op codes SHALL be: 0 ADD, 1 SUB, 2 ADDW, 3 SUBW, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 SLLW, 11 SRLW, 12 SRAW, 13 SLTS, 14 SLTU, 15 EQ, 16 NE, 17 LTS, 18 LTU, 19 GES, 20 GEU, 21 MIN, 22 MAX, 23 MINU, 24 MAXU, 25 ROL, 26 ROR, 27 CLZ, 28 CPOP.
REQ-016 Codes 29-31 SHALL yield result 0 and branch_res 1, with no error.
REQ-017 Add and sub SHALL wrap modulo 2^XLEN.
REQ-018 W ops SHALL compute on bits [31:0] and sign-extend bit 31 of the result to XLEN.
REQ-019 When XLEN=32, W ops SHALL behave identically to their non-W counterparts.
REQ-020 Shift and rotate amounts SHALL be operand_b[$clog2(XLEN)-1:0]; W shifts SHALL use operand_b[4:0].
REQ-021 SLTS/SLTU SHALL return zero-extended 1 or 0 (signed or unsigned a<b).
REQ-022 branch_res SHALL be EQ a==b, NE a!=b, LTS/LTU a<b, GES/GEU a>=b; all other ops SHALL give 1.
REQ-023 CLZ of 0 SHALL return XLEN; CPOP SHALL count set bits of operand_a.
REQ-024 Result, branch_res and tag SHALL be computed combinationally from the inputs and captured in stage 1; stages 2..STAGES SHALL be pure delay registers.
REQ-025 Each stage k SHALL hold a valid bit and load when it is empty or when stage k+1 loads; the last stage SHALL advance when out_ready_i is high.
REQ-026 in_ready_o SHALL equal the stage-1 load condition and SHALL be independent of in_valid_i.
REQ-027 An accepted operation (in_valid_i & in_ready_o) SHALL appear on the outputs exactly STAGES cycles later when not stalled.
REQ-028 The pipeline SHALL sustain one operation per cycle and SHALL never drop or duplicate an operation.
REQ-029 While out_valid_o=1 and out_ready_i=0, result_o, branch_res_o and trans_id_o SHALL hold stable.
REQ-030 A full pipeline SHALL accept a new operation in the same cycle that out_ready_i releases the oldest one.
REQ-031 flush_i SHALL clear all valid bits at the next edge and force in_ready_o to 0 in the flush cycle; an operation offered in that cycle SHALL NOT be accepted.
REQ-032 Results SHALL emerge in acceptance order.

Reset
REQ-033 rst_i sampled high SHALL clear all valid bits and stage data, giving out_valid_o=0, result_o=0, branch_res_o=0 and trans_id_o=0 after the edge.
REQ-034 rst_i asserted mid-operation SHALL discard all in-flight operations with no output.
REQ-035 rst_i SHALL take priority over flush_i.

Configuration
REQ-036 With ALU_BITMANIP_EN defined, ops 21-28 SHALL be implemented as specified.
REQ-037 Without ALU_BITMANIP_EN, ops 21-28 SHALL behave as codes 29-31 and their datapath logic SHALL be absent.

Verification
REQ-038 XLEN=64, STAGES=1: ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0 one cycle later; ADDW a=0x7FFF_FFFF, b=1 -> result 0xFFFF_FFFF_8000_0000.
REQ-039 STAGES=3: 10 back-to-back ops with out_ready_i=1 -> first out_valid_o at cycle 3, then 10 consecutive results with tags in order.
REQ-040 STAGES=2: hold out_ready_i=0 for 5 cycles -> in_ready_o drops after 2 accepts and outputs stay stable; releasing out_ready_i -> accept and drain in the same cycle.
REQ-041 Assert flush_i with 3 ops in flight and in_valid_i=1 -> in_ready_o=0 that cycle and out_valid_o=0 for the following STAGES cycles.
REQ-042 With ALU_BITMANIP_EN: CLZ 0 -> 64, CPOP 0xF0 -> 4, ROR 1 by 1 -> 0x8000_0000_0000_0000, MIN a=-1, b=1 -> -1; without the macro, the same four ops -> result 0.
REQ-043 GES a=-5, b=3 -> branch_res_o=0; GEU a=-5, b=3 -> branch_res_o=1; rst_i pulse mid-stream -> out_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : integer ALU with branch compare, tag return and an elastic
//            STAGES-deep output pipeline. Ops 21-28 built only with ALU_BITMANIP_EN.
// Revision  : 1.0
// ============================================================================
module alu_pipe #(
  parameter int XLEN          = 64,
  parameter int STAGES        = 1,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [4:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     branch_res_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int c_shw = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic                     branch;
    logic [TRANS_ID_BITS-1:0] id;
  } stage_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [c_shw-1:0] shamt;
  logic [4:0]       shamt_w;
  logic [31:0]      a_w;
  logic [31:0]      b_w;
  logic             signed_lt;
  logic             unsigned_lt;
  logic             equal;
  logic [XLEN-1:0]  alu_res;
  logic             alu_br;
  stage_t           alu_out;

  assign shamt       = operand_b_i[c_shw-1:0];
  assign shamt_w     = operand_b_i[4:0];
  assign a_w         = operand_a_i[31:0];
  assign b_w         = operand_b_i[31:0];
  assign signed_lt   = $signed(operand_a_i) < $signed(operand_b_i);
  assign unsigned_lt = operand_a_i < operand_b_i;
  assign equal       = operand_a_i == operand_b_i;

`ifdef ALU_BITMANIP_EN
  logic [2*XLEN-1:0] rot_l;
  logic [2*XLEN-1:0] rot_r;
  logic [XLEN-1:0]   clz_cnt;
  logic [XLEN-1:0]   pop_cnt;

  assign rot_l = {operand_a_i, operand_a_i} << shamt;
  assign rot_r = {operand_a_i, operand_a_i} >> shamt;

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    clz_cnt = XLEN'(XLEN);
    pop_cnt = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (operand_a_i[i]) clz_cnt = XLEN'(XLEN - 1 - i);
      pop_cnt = pop_cnt + XLEN'(operand_a_i[i]);
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b1;
    case (op_i)
      5'd0:  alu_res = operand_a_i + operand_b_i;
      5'd1:  alu_res = operand_a_i - operand_b_i;
      5'd2:  alu_res = sext32(a_w + b_w);
      5'd3:  alu_res = sext32(a_w - b_w);
      5'd4:  alu_res = operand_a_i & operand_b_i;
      5'd5:  alu_res = operand_a_i | operand_b_i;
      5'd6:  alu_res = operand_a_i ^ operand_b_i;
      5'd7:  alu_res = operand_a_i << shamt;
      5'd8:  alu_res = operand_a_i >> shamt;
      5'd9:  alu_res = $signed(operand_a_i) >>> shamt;
      5'd10: alu_res = sext32(a_w << shamt_w);
      5'd11: alu_res = sext32(a_w >> shamt_w);
      5'd12: alu_res = sext32($signed(a_w) >>> shamt_w);
      5'd13: alu_res = {{(XLEN-1){1'b0}}, signed_lt};
      5'd14: alu_res = {{(XLEN-1){1'b0}}, unsigned_lt};
      5'd15: alu_br  = equal;
      5'd16: alu_br  = ~equal;
      5'd17: alu_br  = signed_lt;
      5'd18: alu_br  = unsigned_lt;
      5'd19: alu_br  = ~signed_lt;
      5'd20: alu_br  = ~unsigned_lt;
`ifdef ALU_BITMANIP_EN
      5'd21: alu_res = signed_lt   ? operand_a_i : operand_b_i;
      5'd22: alu_res = signed_lt   ? operand_b_i : operand_a_i;
      5'd23: alu_res = unsigned_lt ? operand_a_i : operand_b_i;
      5'd24: alu_res = unsigned_lt ? operand_b_i : operand_a_i;
      5'd25: alu_res = rot_l[2*XLEN-1:XLEN];
      5'd26: alu_res = rot_r[XLEN-1:0];
      5'd27: alu_res = clz_cnt;
      5'd28: alu_res = pop_cnt;
`endif
      default: ;
    endcase
    alu_out.result = alu_res;
    alu_out.branch = alu_br;
    alu_out.id     = trans_id_i;
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] stage_load;
  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];

  // A stage may load when empty or when its successor drains it this cycle.
  always_comb begin
    stage_load             = '0;
    stage_load[STAGES-1]   = ~valid_q[STAGES-1] | out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      stage_load[k] = ~valid_q[k] | stage_load[k+1];
    end
    in_ready_o = stage_load[0] & ~flush_i;

    valid_d = valid_q;
    stage_d = stage_q;
    if (stage_load[0]) begin
      valid_d[0] = in_valid_i & in_ready_o;
      if (in_valid_i & in_ready_o) stage_d[0] = alu_out;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (stage_load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) stage_d[k] = stage_q[k-1];
      end
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign out_valid_o  = valid_q[STAGES-1];
  assign result_o     = stage_q[STAGES-1].result;
  assign branch_res_o = stage_q[STAGES-1].branch;
  assign trans_id_o   = stage_q[STAGES-1].id;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : scoreboard bench for alu_pipe (XLEN=64, STAGES=3).
// Revision    : 1.0
// ============================================================================
module tb_alu_pipe;

  localparam int XLEN   = 64;
  localparam int STAGES = 3;
  localparam int TIDW   = 3;

`ifdef ALU_BITMANIP_EN
  localparam logic [63:0] E_CLZ = 64'd64;
  localparam logic [63:0] E_POP = 64'd4;
  localparam logic [63:0] E_ROR = 64'h8000_0000_0000_0000;
  localparam logic [63:0] E_MIN = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] E_CLZ = 64'd0;
  localparam logic [63:0] E_POP = 64'd0;
  localparam logic [63:0] E_ROR = 64'd0;
  localparam logic [63:0] E_MIN = 64'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [4:0]      op_i = '0;
  logic [XLEN-1:0] operand_a_i = '0;
  logic [XLEN-1:0] operand_b_i = '0;
  logic [TIDW-1:0] trans_id_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b1;
  logic [XLEN-1:0] result_o;
  logic            branch_res_o;
  logic [TIDW-1:0] trans_id_o;

  alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .trans_id_i(trans_id_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .branch_res_o(branch_res_o), .trans_id_o(trans_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      op;
    logic [63:0]     res;
    logic            br;
    logic [TIDW-1:0] tid;
    bit              chk_res;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  exp_t            pend;
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              pops = 0;
  int              first_pop = -1;
  int              last_pop = -1;
  bit              lat_chk = 1'b0;
  bit              rand_rdy = 1'b0;
  logic [TIDW-1:0] tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag_s, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic br, output bit chk);
    logic [31:0] w;
    int          n;
    r = '0; br = 1'b1; chk = 1'b1; w = '0;
    n = int'(b[5:0]);
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  begin w = a[31:0] + b[31:0]; r = {{32{w[31]}}, w}; end
      5'd3:  begin w = a[31:0] - b[31:0]; r = {{32{w[31]}}, w}; end
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = a << n;
      5'd8:  r = a >> n;
      5'd9:  r = $signed(a) >>> n;
      5'd10: begin w = a[31:0] << b[4:0]; r = {{32{w[31]}}, w}; end
      5'd11: begin w = a[31:0] >> b[4:0]; r = {{32{w[31]}}, w}; end
      5'd12: begin w = $signed(a[31:0]) >>> b[4:0]; r = {{32{w[31]}}, w}; end
      5'd13: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'd14: r = (a < b) ? 64'd1 : 64'd0;
      5'd15: begin br = (a == b); chk = 1'b0; end
      5'd16: begin br = (a != b); chk = 1'b0; end
      5'd17: begin br = ($signed(a) < $signed(b)); chk = 1'b0; end
      5'd18: begin br = (a < b); chk = 1'b0; end
      5'd19: begin br = ($signed(a) >= $signed(b)); chk = 1'b0; end
      5'd20: begin br = (a >= b); chk = 1'b0; end
`ifdef ALU_BITMANIP_EN
      5'd21: r = ($signed(a) < $signed(b)) ? a : b;
      5'd22: r = ($signed(a) > $signed(b)) ? a : b;
      5'd23: r = (a < b) ? a : b;
      5'd24: r = (a > b) ? a : b;
      5'd25: r = (n == 0) ? a : ((a << n) | (a >> (64 - n)));
      5'd26: r = (n == 0) ? a : ((a >> n) | (a << (64 - n)));
      5'd27: begin
        r = 64'd64;
        for (int i = 63; i >= 0; i--) if (a[i]) begin r = 64'(63 - i); break; end
      end
      5'd28: r = 64'($countones(a));
`endif
      default: ;
    endcase
  endfunction

  // Handshakes are observed mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_i || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq($sformatf("tid_op%0d", e.op), 64'(trans_id_o), 64'(e.tid));
          check_eq($sformatf("br_op%0d", e.op), 64'(branch_res_o), 64'(e.br));
          if (e.chk_res) check_eq($sformatf("res_op%0d", e.op), result_o, e.res);
          if (lat_chk) begin
            check_eq("latency", 64'(cyc - e.cyc), 64'(STAGES));
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        pend.cyc = cyc;
        sb.push_back(pend);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // mode 0: model expectation; 1: given result+branch; 2: given branch only
  task automatic set_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int mode, input logic [63:0] er, input logic eb);
    logic [63:0] r;
    logic        br;
    bit          chk;
    ref_alu(op, a, b, r, br, chk);
    if (mode != 0) begin r = er; br = eb; chk = (mode == 1); end
    op_i = op; operand_a_i = a; operand_b_i = b; trans_id_i = tag; in_valid_i = 1'b1;
    pend.op = op; pend.res = r; pend.br = br; pend.tid = tag; pend.chk_res = chk; pend.cyc = 0;
    tag = tag + 1'b1;
  endtask

  task automatic wait_accept();
    int g;
    bit acc;
    g = 0;
    do begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
      g++;
    end while (!acc && g < 200);
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drive(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int mode, input logic [63:0] er, input logic eb);
    set_op(op, a, b, mode, er, eb);
    wait_accept();
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid_i = 1'b0;
    while (sb.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          nacc;
    bit          acc;
    logic [63:0] ra;
    logic [63:0] rb;

    tick(); tick();
    check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_result", result_o, 64'd0);
    check_eq("rst_branch", 64'(branch_res_o), 64'd0);
    check_eq("rst_tid", 64'(trans_id_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);

    drive(5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 1'b1);
    drive(5'd2,  64'h7FFF_FFFF, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    drive(5'd1,  64'd0, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(5'd3,  64'h1_0000_0000, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(5'd10, 64'd1, 64'h3F, 1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    drive(5'd9,  64'h8000_0000_0000_0000, 64'd63, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(5'd8,  64'h8000_0000_0000_0000, 64'd63, 1, 64'd1, 1'b1);
    drive(5'd12, 64'h8000_0000, 64'd4, 1, 64'hFFFF_FFFF_F800_0000, 1'b1);
    drive(5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd1, 1'b1);
    drive(5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 1'b1);
    drive(5'd19, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 2, 64'd0, 1'b0);
    drive(5'd20, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 2, 64'd0, 1'b1);
    drive(5'd17, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 2, 64'd0, 1'b1);
    drive(5'd18, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 2, 64'd0, 1'b0);
    drive(5'd16, 64'd5, 64'd5, 2, 64'd0, 1'b0);
    drive(5'd30, 64'd7, 64'd9, 1, 64'd0, 1'b1);
    drive(5'd27, 64'd0, 64'd0, 1, E_CLZ, 1'b1);
    drive(5'd28, 64'hF0, 64'd0, 1, E_POP, 1'b1);
    drive(5'd26, 64'd1, 64'd1, 1, E_ROR, 1'b1);
    drive(5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, E_MIN, 1'b1);
    drain();

    // Back-to-back burst with a free-running consumer
    lat_chk = 1'b1;
    pops = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 10; i++)
      drive(5'($urandom_range(0, 14)), {$urandom, $urandom}, 64'($urandom_range(0, 70)), 0, 64'd0, 1'b0);
    drain();
    lat_chk = 1'b0;
    check_eq("burst_count", 64'(pops), 64'd10);
    check_eq("burst_span", 64'(last_pop - first_pop), 64'd9);

    // Backpressure: pipeline fills, holds its head, then accepts on release
    out_ready_i = 1'b0;
    nacc = 0;
    set_op(5'($urandom_range(0, 14)), {$urandom, $urandom}, 64'($urandom_range(0, 70)), 0, 64'd0, 1'b0);
    for (int c = 0; c < STAGES + 2; c++) begin
      @(negedge clk);
      acc = in_ready_o;
      if (acc) nacc++;
      if (out_valid_o && sb.size() > 0) begin
        check_eq("stall_hold_res", result_o, sb[0].res);
        check_eq("stall_hold_tid", 64'(trans_id_o), 64'(sb[0].tid));
      end
      tick();
      if (acc) set_op(5'($urandom_range(0, 14)), {$urandom, $urandom}, 64'($urandom_range(0, 70)), 0, 64'd0, 1'b0);
    end
    check_eq("stall_accepts", 64'(nacc), 64'(STAGES));
    check_eq("stall_in_ready", 64'(in_ready_o), 64'd0);
    check_eq("stall_out_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    #1;
    check_eq("release_in_ready", 64'(in_ready_o), 64'd1);
    wait_accept();
    drain();

    // Flush with ops in flight and a new op offered
    for (int i = 0; i < 3; i++) drive(5'd0, 64'(i), 64'd1, 0, 64'd0, 1'b0);
    set_op(5'd6, 64'hAA, 64'h55, 0, 64'd0, 1'b0);
    flush_i = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    for (int c = 0; c < STAGES; c++) begin
      @(negedge clk);
      check_eq("flush_out_valid", 64'(out_valid_o), 64'd0);
    end
    drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = ra;
      drive(5'($urandom_range(0, 31)), ra, rb, 0, 64'd0, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        in_valid_i = 1'b0;
        tick();
      end
    end
    rand_rdy = 1'b0;
    out_ready_i = 1'b1;
    drain();

    // Reset pulse mid-stream discards in-flight ops
    drive(5'd0, 64'd1, 64'd2, 0, 64'd0, 1'b0);
    drive(5'd1, 64'd9, 64'd2, 0, 64'd0, 1'b0);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("midrst_out_valid", 64'(out_valid_o), 64'd0);
    for (int c = 0; c < STAGES; c++) begin
      @(negedge clk);
      check_eq("midrst_quiet", 64'(out_valid_o), 64'd0);
    end
    drive(5'd4, 64'hF0F0, 64'hFF00, 0, 64'd0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
